jump_input_ctrl: RTL and testbench



---
 rtl/game_pkg.sv | 35 +++
 rtl/jump_input_ctrl_if.sv | 27 ++
 rtl/key_debouncer.sv | 52 +++++
 rtl/jump_input_ctrl.sv | 135 +++++++++++++
 tb/tb_jump_input_ctrl.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared types and keycode constants for the player-input path.
// Keycodes are USB HID usage IDs as exported by the SoC PIO.
package game_pkg;

    typedef enum logic [1:0] {
        KC_NONE    = 2'd0,
        KC_JUMP    = 2'd1,
        KC_PAUSE   = 2'd2,
        KC_RESTART = 2'd3
    } key_class_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PENDING  = 2'd1,
        ST_COOLDOWN = 2'd2
    } jump_state_t;

    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_P     = 8'h13;
    localparam logic [7:0] KEY_R     = 8'h15;

    function automatic key_class_t classify_key(input logic [7:0] kc);
        key_class_t cls;
        case (kc)
            KEY_SPACE, KEY_W, KEY_UP: cls = KC_JUMP;
            KEY_P:                    cls = KC_PAUSE;
            KEY_R:                    cls = KC_RESTART;
            default:                  cls = KC_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/jump_input_ctrl_if.sv
// Signal bundle between the game-side logic and jump_input_ctrl.
// All outputs are registered; request outputs are single-cycle pulses with no back-pressure.
interface jump_input_ctrl_if;
    import game_pkg::*;

    logic [7:0]  keycode;
    logic        on_ground;
    logic        pause;
    logic        gameplay;
    logic        jump_req;
    logic        pause_toggle;
    logic        restart_req;
    key_class_t  key_class;
    logic        jump_pending;
    jump_state_t jump_state;

    modport master (
        output keycode, on_ground, pause, gameplay,
        input  jump_req, pause_toggle, restart_req, key_class, jump_pending, jump_state
    );

    modport slave (
        input  keycode, on_ground, pause, gameplay,
        output jump_req, pause_toggle, restart_req, key_class, jump_pending, jump_state
    );

endinterface

// File: rtl/key_debouncer.sv
// Registers the raw key class and accepts it once it has been seen on DEBOUNCE_FRAMES
// consecutive samples; press_edge_o flags the cycle in which key_class_o changes to a non-NONE class.
module key_debouncer
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_FRAMES = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  key_class_t raw_class_i,
    output key_class_t key_class_o,
    output logic       press_edge_o,
    output key_class_t press_class_o
);

    localparam logic [2:0] ACCEPT_CNT = 3'(DEBOUNCE_FRAMES - 1);
    localparam logic [2:0] STABLE_MAX = 3'd7;

    key_class_t raw_q, raw_d;
    key_class_t key_class_q, key_class_d;
    logic [2:0] stable_q, stable_d;
    logic       accept;

    // raw_q is the previous sample; stable_q counts repeats of it beyond the first.
    always_comb begin
        raw_d = raw_class_i;
        if (raw_class_i == raw_q) begin
            stable_d = (stable_q == STABLE_MAX) ? stable_q : stable_q + 3'd1;
        end else begin
            stable_d = 3'd0;
        end
        accept      = (stable_q >= ACCEPT_CNT);
        key_class_d = accept ? raw_q : key_class_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            raw_q       <= KC_NONE;
            stable_q    <= 3'd0;
            key_class_q <= KC_NONE;
        end else begin
            raw_q       <= raw_d;
            stable_q    <= stable_d;
            key_class_q <= key_class_d;
        end
    end

    assign key_class_o   = key_class_q;
    assign press_edge_o  = accept && (raw_q != key_class_q) && (raw_q != KC_NONE);
    assign press_class_o = raw_q;

endmodule

// File: rtl/jump_input_ctrl.sv
// Keyboard front end for the player: debounced classification, jump buffering,
// hold-to-repeat on landing with a cooldown, and pause/restart request pulses.
module jump_input_ctrl
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_FRAMES = 2,
    parameter int unsigned BUFFER_FRAMES   = 6,
    parameter int unsigned COOLDOWN_FRAMES = 3
) (
    input logic               Clk,
    input logic               Reset,
    jump_input_ctrl_if.slave  bus
);

    localparam logic [3:0] BUF_LOAD  = 4'(BUFFER_FRAMES);
    localparam logic [3:0] COOL_LOAD = 4'(COOLDOWN_FRAMES);

    key_class_t  raw_class;
    key_class_t  key_class;
    key_class_t  press_class;
    logic        press_edge;
    logic        jump_edge;
    logic        gated;
    logic [3:0]  buf_dec;
    logic [3:0]  cool_buf_next;

    jump_state_t state_q;
    logic [3:0]  buf_q;
    logic [3:0]  cool_q;
    logic        jump_req_q;
    logic        pending_q;
    logic        pause_toggle_q;
    logic        restart_req_q;

    assign raw_class = classify_key(bus.keycode);

    key_debouncer #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_debouncer (
        .Clk           (Clk),
        .Reset         (Reset),
        .raw_class_i   (raw_class),
        .key_class_o   (key_class),
        .press_edge_o  (press_edge),
        .press_class_o (press_class)
    );

    assign jump_edge = press_edge && (press_class == KC_JUMP);
    assign gated     = bus.pause || !bus.gameplay;
    assign buf_dec   = (buf_q == 4'd0) ? 4'd0 : buf_q - 4'd1;
    // A press during cooldown is remembered in buf_q, which ages alongside the cooldown.
    assign cool_buf_next = jump_edge ? BUF_LOAD : buf_dec;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q        <= ST_IDLE;
            buf_q          <= 4'd0;
            cool_q         <= 4'd0;
            jump_req_q     <= 1'b0;
            pending_q      <= 1'b0;
            pause_toggle_q <= 1'b0;
            restart_req_q  <= 1'b0;
        end else begin
            pause_toggle_q <= press_edge && (press_class == KC_PAUSE);
            restart_req_q  <= press_edge && (press_class == KC_RESTART);
            jump_req_q     <= 1'b0;
            pending_q      <= 1'b0;
            if (gated) begin
                state_q <= ST_IDLE;
                buf_q   <= 4'd0;
                cool_q  <= 4'd0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (jump_edge || (key_class == KC_JUMP && bus.on_ground)) begin
                            if (bus.on_ground) begin
                                jump_req_q <= 1'b1;
                                cool_q     <= COOL_LOAD;
                                state_q    <= ST_COOLDOWN;
                            end else begin
                                buf_q     <= BUF_LOAD;
                                pending_q <= 1'b1;
                                state_q   <= ST_PENDING;
                            end
                        end
                    end
                    ST_PENDING: begin
                        if (bus.on_ground) begin
                            jump_req_q <= 1'b1;
                            buf_q      <= 4'd0;
                            cool_q     <= COOL_LOAD;
                            state_q    <= ST_COOLDOWN;
                        end else if (jump_edge) begin
                            buf_q     <= BUF_LOAD;
                            pending_q <= 1'b1;
                        end else if (buf_q <= 4'd1) begin
                            buf_q   <= 4'd0;
                            state_q <= ST_IDLE;
                        end else begin
                            buf_q     <= buf_dec;
                            pending_q <= 1'b1;
                        end
                    end
                    ST_COOLDOWN: begin
                        buf_q <= cool_buf_next;
                        if (cool_q <= 4'd1) begin
                            cool_q <= 4'd0;
                            if (cool_buf_next != 4'd0) begin
                                pending_q <= 1'b1;
                                state_q   <= ST_PENDING;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            cool_q <= cool_q - 4'd1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        buf_q   <= 4'd0;
                        cool_q  <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign bus.jump_req     = jump_req_q;
    assign bus.pause_toggle = pause_toggle_q;
    assign bus.restart_req  = restart_req_q;
    assign bus.key_class    = key_class;
    assign bus.jump_pending = pending_q;
    assign bus.jump_state   = state_q;

endmodule

// File: tb/tb_jump_input_ctrl.sv
// Directed bench for jump_input_ctrl with default parameters (debounce 2, buffer 6, cooldown 3).
// Cycle c counts rising edges after reset release; outputs are sampled 1 ns after each edge.
module tb_jump_input_ctrl;
    import game_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    jump_input_ctrl_if bus();

    jump_input_ctrl dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.keycode   = 8'h00;
        bus.on_ground = 1'b0;
        bus.pause     = 1'b0;
        bus.gameplay  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst key_class", bus.key_class, 8'd0);
        check("rst jump_req", bus.jump_req, 8'd0);
        check("rst pending", bus.jump_pending, 8'd0);
        check("rst pause_toggle", bus.pause_toggle, 8'd0);
        check("rst restart_req", bus.restart_req, 8'd0);
        check("rst state", bus.jump_state, ST_IDLE);

        // Space held while grounded: first jump at c3, then every 4 cycles.
        bus.keycode   = KEY_SPACE;
        bus.on_ground = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            check($sformatf("hold jump_req c%0d", c), bus.jump_req,
                  (c == 3 || c == 7 || c == 11) ? 8'd1 : 8'd0);
            check($sformatf("hold pending c%0d", c), bus.jump_pending, 8'd0);
            if (c == 2) check("hold key_class c2", bus.key_class, 8'd0);
            if (c == 3) check("hold key_class c3", bus.key_class, 8'd1);
            if (c == 3) check("hold state c3", bus.jump_state, ST_COOLDOWN);
            if (c == 6) check("hold state c6", bus.jump_state, ST_IDLE);
        end

        // Single-cycle glitch on space is rejected.
        do_reset();
        bus.on_ground = 1'b1;
        bus.keycode   = KEY_SPACE;
        tick();
        bus.keycode = 8'h00;
        for (int c = 2; c <= 8; c++) begin
            tick();
            check($sformatf("glitch key_class c%0d", c), bus.key_class, 8'd0);
            check($sformatf("glitch jump_req c%0d", c), bus.jump_req, 8'd0);
        end

        // Airborne press accepted at c3, released, landing seen at c7 fires once.
        do_reset();
        bus.keycode = KEY_W;
        for (int c = 1; c <= 12; c++) begin
            tick();
            check($sformatf("buf4 pending c%0d", c), bus.jump_pending,
                  (c >= 3 && c <= 6) ? 8'd1 : 8'd0);
            check($sformatf("buf4 jump_req c%0d", c), bus.jump_req, (c == 7) ? 8'd1 : 8'd0);
            if (c == 3) bus.keycode = 8'h00;
            if (c == 6) bus.on_ground = 1'b1;
        end

        // Landing 8 cycles after the press: buffer expires after 6 cycles, no jump.
        do_reset();
        bus.keycode = KEY_UP;
        for (int c = 1; c <= 14; c++) begin
            tick();
            check($sformatf("buf8 pending c%0d", c), bus.jump_pending,
                  (c >= 3 && c <= 8) ? 8'd1 : 8'd0);
            check($sformatf("buf8 jump_req c%0d", c), bus.jump_req, 8'd0);
            if (c == 3) bus.keycode = 8'h00;
            if (c == 10) bus.on_ground = 1'b1;
        end

        // P then R held 20 cycles each while paused: one pulse each, no jumps.
        do_reset();
        bus.pause     = 1'b1;
        bus.on_ground = 1'b1;
        bus.keycode   = KEY_P;
        for (int c = 1; c <= 40; c++) begin
            tick();
            check($sformatf("pr pause_toggle c%0d", c), bus.pause_toggle, (c == 3) ? 8'd1 : 8'd0);
            check($sformatf("pr restart_req c%0d", c), bus.restart_req, (c == 23) ? 8'd1 : 8'd0);
            check($sformatf("pr jump_req c%0d", c), bus.jump_req, 8'd0);
            if (c == 20) bus.keycode = KEY_R;
        end
        check("pr key_class", bus.key_class, 8'd3);

        // Held jump while gameplay=0 fires on the cycle after un-gating.
        do_reset();
        bus.gameplay  = 1'b0;
        bus.on_ground = 1'b1;
        bus.keycode   = KEY_SPACE;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check($sformatf("gate jump_req c%0d", c), bus.jump_req, (c == 6) ? 8'd1 : 8'd0);
            if (c == 5) check("gate state c5", bus.jump_state, ST_IDLE);
            if (c == 5) bus.gameplay = 1'b1;
        end

        // Reset in the middle of a buffered jump discards it.
        do_reset();
        bus.keycode = KEY_SPACE;
        for (int c = 1; c <= 3; c++) tick();
        check("rstmid pending c3", bus.jump_pending, 8'd1);
        bus.keycode = 8'h00;
        tick();
        check("rstmid pending c4", bus.jump_pending, 8'd1);
        rst = 1'b1;
        tick();
        check("rstmid pending after", bus.jump_pending, 8'd0);
        check("rstmid state after", bus.jump_state, ST_IDLE);
        check("rstmid key_class after", bus.key_class, 8'd0);
        rst           = 1'b0;
        bus.on_ground = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check($sformatf("rstmid jump_req c%0d", c), bus.jump_req, 8'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
